// File: rtl/fetch_unit.sv
// Fetch unit: owns the program counter, fetches instruction words over a
// req/ack handshake into the instruction register, and sequences
// BOOT -> FETCH -> EXEC -> (FETCH | HALT) using the decoder's jump/hlt.
module fetch_unit #(
  parameter int unsigned AW = 8,   // program address / jump target width
  parameter int unsigned IW = 12   // instruction word width, IW >= AW + 4
) (
  input  logic          clk,
  input  logic          rst,

  // Program memory handshake
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic [IW-1:0] mem_data,
  input  logic          mem_ack,

  // Decoder interface
  output logic [3:0]    ins,
  output logic [AW-1:0] operand,
  output logic          exec_en,
  input  logic          jump,
  input  logic          hlt,

  // Run control
  input  logic          resume,
  output logic          halted,
  output logic [AW-1:0] pc
);

  typedef enum logic [1:0] {
    StBoot  = 2'd0,
    StFetch = 2'd1,
    StExec  = 2'd2,
    StHalt  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] ir_q, ir_d;

  localparam logic [AW-1:0] PcOne = {{(AW-1){1'b0}}, 1'b1};

  // State, PC and IR registers; async reset aborts any fetch in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StBoot;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state logic: inputs only matter in the state that owns them.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      StBoot: begin
        state_d = StFetch;
      end
      StFetch: begin
        if (mem_ack) begin
          ir_d    = mem_data;
          pc_d    = pc_q + PcOne;  // wraps modulo 2^AW
          state_d = StExec;
        end
      end
      StExec: begin
        // hlt wins over jump; a halt keeps the already-incremented PC.
        if (hlt) begin
          state_d = StHalt;
        end else if (jump) begin
          pc_d    = ir_q[AW-1:0];
          state_d = StFetch;
        end else begin
          state_d = StFetch;
        end
      end
      StHalt: begin
        if (resume) begin
          state_d = StFetch;
        end
      end
      default: begin
        state_d = StBoot;
      end
    endcase
  end

  // Control outputs decode the state register only, so they cannot glitch
  // on inputs and there is no combinational path back through the decoder.
  always_comb begin
    mem_req = (state_q == StFetch);
    exec_en = (state_q == StExec);
    halted  = (state_q == StHalt);
  end

  // Datapath outputs come straight from the PC and IR registers.
  always_comb begin
    mem_addr = pc_q;
    pc       = pc_q;
    ins      = ir_q[IW-1:IW-4];
    operand  = ir_q[AW-1:0];
  end

endmodule
